// File: rtl/semaforo_temporizado_pkg.sv
// Shared types for the timed A/B crossing controller: phase enum, lamp
// triple per street and the Moore decode from phase to lamps.
package semaforo_pkg;

  typedef enum logic [2:0] {
    VERDE_B   = 3'd0,
    AMARELO_B = 3'd1,
    VERM_BA   = 3'd2,
    VERDE_A   = 3'd3,
    AMARELO_A = 3'd4,
    VERM_AB   = 3'd5
  } estado_t;

  typedef struct packed {
    logic verde;
    logic amarelo;
    logic vermelho;
  } luz_t;

  typedef struct packed {
    luz_t a;
    luz_t b;
  } luzes_t;

  localparam luz_t LUZ_VERDE   = luz_t'(3'b100);
  localparam luz_t LUZ_AMARELO = luz_t'(3'b010);
  localparam luz_t LUZ_VERM    = luz_t'(3'b001);

  // Unused encodings fall back to the default pattern (B green, A red) so
  // the lamps stay one-hot per street even before the FSM recovers.
  function automatic luzes_t decodifica(estado_t e);
    luzes_t l;
    l.a = LUZ_VERM;
    l.b = LUZ_VERDE;
    case (e)
      VERDE_B:   begin l.a = LUZ_VERM;    l.b = LUZ_VERDE;   end
      AMARELO_B: begin l.a = LUZ_VERM;    l.b = LUZ_AMARELO; end
      VERM_BA:   begin l.a = LUZ_VERM;    l.b = LUZ_VERM;    end
      VERDE_A:   begin l.a = LUZ_VERDE;   l.b = LUZ_VERM;    end
      AMARELO_A: begin l.a = LUZ_AMARELO; l.b = LUZ_VERM;    end
      VERM_AB:   begin l.a = LUZ_VERM;    l.b = LUZ_VERM;    end
      default:   begin l.a = LUZ_VERM;    l.b = LUZ_VERDE;   end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/semaforo_temporizado_if.sv
// Sensor/lamp bundle of the crossing. All signals are plain levels: there
// is no valid/ready handshake; AB is sampled every cycle through a
// synchroniser and the lamps reflect the current phase continuously.
interface semaforo_temporizado_if;
  logic [1:0] AB;
  logic       VDA, AMA, VMA;
  logic       VDB, AMB, VMB;

  modport master (output AB, input VDA, AMA, VMA, VDB, AMB, VMB);
  modport slave  (input AB, output VDA, AMA, VMA, VDB, AMB, VMB);
endinterface

// File: rtl/semaforo_temporizado_sincronizador.sv
// Two-flop synchroniser for asynchronous level inputs, reset to zero.
module sincronizador #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages; q is safe to use in the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/semaforo_temporizado.sv
// Timed Moore controller for the A/B crossing: green/yellow/all-red phases
// with minimum green, a fairness cut-off on A green, and synchronised sensors.
module semaforo_temporizado
  import semaforo_pkg::*;
#(
  parameter int T_VERDE_MIN = 4,
  parameter int T_VERDE_MAX = 8,
  parameter int T_AMARELO   = 2,
  parameter int T_VERMELHO  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  semaforo_temporizado_if.slave   bus,
  output estado_t                 estado_dbg
);

  localparam int CW = $clog2(T_VERDE_MAX);
  localparam logic [CW-1:0] CNT_MIN  = CW'(T_VERDE_MIN - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(T_VERDE_MAX - 1);
  localparam logic [CW-1:0] CNT_AMA  = CW'(T_AMARELO - 1);
  localparam logic [CW-1:0] CNT_VERM = CW'(T_VERMELHO - 1);

  estado_t       estado, estado_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    ab_s;
  logic          a_s, b_s;
  luzes_t        luzes;

  sincronizador #(.W(2)) u_sinc (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.AB),
    .q     (ab_s)
  );

  assign a_s = ab_s[1];
  assign b_s = ab_s[0];

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= VERDE_B;
    else        estado <= estado_nx;
  end

  // Dwell counter: restarts on each phase change, saturates at the max green.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (estado_nx != estado) cnt <= '0;
    else if (cnt != CNT_MAX)     cnt <= cnt + CW'(1);
  end

  // Next phase. Yellow and all-red ignore the sensors so a started
  // clearance always runs to completion.
  always_comb begin
    estado_nx = estado;
    case (estado)
      VERDE_B:   if (cnt >= CNT_MIN && a_s)             estado_nx = AMARELO_B;
      AMARELO_B: if (cnt == CNT_AMA)                    estado_nx = VERM_BA;
      VERM_BA:   if (cnt == CNT_VERM)                   estado_nx = VERDE_A;
      VERDE_A:   if (cnt >= CNT_MIN &&
                     (!a_s || (b_s && cnt == CNT_MAX))) estado_nx = AMARELO_A;
      AMARELO_A: if (cnt == CNT_AMA)                    estado_nx = VERM_AB;
      VERM_AB:   if (cnt == CNT_VERM)                   estado_nx = VERDE_B;
      default:                                          estado_nx = VERDE_B;
    endcase
  end

  // Moore lamp decode straight from the phase register.
  always_comb begin
    luzes = decodifica(estado);
  end

  assign bus.VDA    = luzes.a.verde;
  assign bus.AMA    = luzes.a.amarelo;
  assign bus.VMA    = luzes.a.vermelho;
  assign bus.VDB    = luzes.b.verde;
  assign bus.AMB    = luzes.b.amarelo;
  assign bus.VMB    = luzes.b.vermelho;
  assign estado_dbg = estado;

endmodule

// File: tb/tb_semaforo_temporizado.sv
// Bench for the timed crossing controller: directed phase-timing steps plus
// a randomized sensor run, all compared against a phase/duration model.
module tb_semaforo_temporizado;
  import semaforo_pkg::*;

  localparam int T_VERDE_MIN = 4;
  localparam int T_VERDE_MAX = 8;
  localparam int T_AMARELO   = 2;
  localparam int T_VERMELHO  = 1;

  // Lamp vector order: {VDA, AMA, VMA, VDB, AMB, VMB}
  localparam logic [5:0] L_VB  = 6'b001100;
  localparam logic [5:0] L_AB  = 6'b001010;
  localparam logic [5:0] L_RR  = 6'b001001;
  localparam logic [5:0] L_VA  = 6'b100001;
  localparam logic [5:0] L_AA  = 6'b010001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ab_drv;
  estado_t    estado_dbg;
  logic [5:0] luzes_obs;

  int errors = 0;
  int checks = 0;

  semaforo_temporizado_if bus ();

  semaforo_temporizado #(
    .T_VERDE_MIN (T_VERDE_MIN),
    .T_VERDE_MAX (T_VERDE_MAX),
    .T_AMARELO   (T_AMARELO),
    .T_VERMELHO  (T_VERMELHO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .estado_dbg (estado_dbg)
  );

  assign bus.AB    = ab_drv;
  assign luzes_obs = {bus.VDA, bus.AMA, bus.VMA, bus.VDB, bus.AMB, bus.VMB};

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phases walk a fixed ring; each has a lamp pattern. Sensors reach the
  // decision through a two-deep history of sampled AB values.
  logic [5:0] padrao [6] = '{L_VB, L_AB, L_RR, L_VA, L_AA, L_RR};
  int         m_fase;
  int         m_tempo;     // cycles already spent in the phase, unbounded
  logic [1:0] m_hist1, m_hist2;

  task automatic model_reset();
    m_fase  = 0;
    m_tempo = 0;
    m_hist1 = 2'b00;
    m_hist2 = 2'b00;
  endtask

  task automatic model_edge();
    bit a, b, sai;
    a = m_hist2[1];
    b = m_hist2[0];
    case (m_fase)
      0:       sai = (m_tempo + 1 >= T_VERDE_MIN) && a;
      3:       sai = (m_tempo + 1 >= T_VERDE_MIN) &&
                     (!a || (b && m_tempo + 1 >= T_VERDE_MAX));
      1, 4:    sai = (m_tempo + 1 == T_AMARELO);
      default: sai = (m_tempo + 1 == T_VERMELHO);
    endcase
    if (sai) begin
      m_fase  = (m_fase + 1) % 6;
      m_tempo = 0;
    end else begin
      m_tempo++;
    end
    m_hist2 = m_hist1;
    m_hist1 = ab_drv;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("luzes", luzes_obs, padrao[m_fase]);
    check("onehot_a", 6'($onehot(luzes_obs[5:3])), 6'd1);
    check("onehot_b", 6'($onehot(luzes_obs[2:0])), 6'd1);
    check("dois_verdes", 6'(luzes_obs[5] & luzes_obs[2]), 6'd0);
  endtask

  // Asynchronous reset pulse issued between clock edges.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("reset_luzes", luzes_obs, L_VB);
    check("reset_estado", 6'(estado_dbg), 6'(VERDE_B));
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // Count consecutive cycles a lamp stays on, starting from a lit cycle.
  task automatic medir(input int idx, output int n);
    n = 1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (luzes_obs[idx]) n++;
      else break;
    end
  endtask

  task automatic esperar(input int idx, input string tag);
    bit achou;
    achou = luzes_obs[idx];
    for (int k = 0; k < 60 && !achou; k++) begin
      tick();
      achou = luzes_obs[idx];
    end
    check(tag, 6'(achou), 6'd1);
  endtask

  logic [5:0] seq_esp [7] = '{L_VB, L_VB, L_VB, L_AB, L_AB, L_RR, L_VA};

  initial begin
    int n;
    rst_n  = 1'b0;
    ab_drv = 2'b00;
    #1;
    reset_pulse();

    // idle: no requests, B stays green
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", luzes_obs, L_VB);
    end

    // A request from cycle 0 after reset
    reset_pulse();
    ab_drv = 2'b10;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("req_a_e%0d", i + 1), luzes_obs, seq_esp[i]);
    end

    // both requesting: fairness cut-off on A green
    ab_drv = 2'b11;
    medir(5, n);
    check("verde_a_max", 6'(n), 6'(T_VERDE_MAX));
    medir(4, n);
    check("amarelo_a_len", 6'(n), 6'(T_AMARELO));
    check("verm_ab", luzes_obs, L_RR);
    tick();
    check("verde_b_apos", luzes_obs, L_VB);
    medir(2, n);
    check("verde_b_min", 6'(n >= T_VERDE_MIN), 6'd1);
    check("volta_a", 6'(luzes_obs[1]), 6'd1);

    // A drops right after entering green: minimum green still honoured
    esperar(5, "entra_verde_a");
    ab_drv = 2'b00;
    medir(5, n);
    check("verde_a_min", 6'(n), 6'(T_VERDE_MIN));
    check("amarelo_apos_min", luzes_obs, L_AA);

    // sensor flips during B yellow: phase completes into A green
    ab_drv = 2'b10;
    esperar(1, "entra_amarelo_b");
    ab_drv = 2'b01;
    esperar(5, "verde_a_apos_toggle");

    // reset in the middle of A yellow
    esperar(4, "entra_amarelo_a");
    #3;
    reset_pulse();
    ab_drv = 2'b00;
    for (int i = 0; i < 5; i++) tick();

    // randomized sensor activity
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ab_drv = 2'($urandom_range(0, 3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
